// File: rtl/cpu_0_ocimem_pkg.sv
// Shared definitions for the OCI debug-memory arbiter.
// Holds the arbiter FSM state type, the jdo field positions used by the JTAG
// command decoder, and the common data/counter widths.
package cpu_0_ocimem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned JDO_W      = 38;

    // jdo field positions
    localparam int unsigned ADDR_LSB   = 17;
    localparam int unsigned RD_BIT     = 35;
    localparam int unsigned CLRERR_BIT = 33;
    localparam int unsigned WDATA_HI   = 34;
    localparam int unsigned WDATA_LO   = 3;

    // Width of the JTAG starvation counter
    localparam int unsigned STARVE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cpu_0_ocimem_cmd_decode.sv
// JTAG debug-memory command decoder.
// Turns take_* strobes plus jdo into a one-deep pending command, owns the
// JTAG address pointer and the monitor_ready / monitor_error status flags.
// Ports:
//   clk, reset                 clock, async active-high reset
//   jdo, take_*                JTAG shift data and command strobes
//   busy                       arbiter is in a read data phase (not IDLE)
//   done                       pending JTAG access completes this cycle
//   pending, pend_wr           pending command valid / is a write
//   pend_data                  write data of the pending command
//   jaddr                      current JTAG word address
//   monitor_ready              no JTAG command outstanding
//   monitor_error              sticky overrun flag
module cpu_0_ocimem_cmd_decode
    import cpu_0_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              busy,
    input  logic              done,
    output logic              pending,
    output logic              pend_wr,
    output logic [DATA_W-1:0] pend_data,
    output logic [ADDR_W-1:0] jaddr,
    output logic              monitor_ready,
    output logic              monitor_error
);

    logic sel_a;
    logic sel_b;
    logic sel_n;
    logic any_strobe;
    logic blocked;
    logic want_rd;
    logic queue_cmd;
    logic overrun;
    logic load_addr;

    // jdo bits that carry nothing for this block
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[JDO_W-1:RD_BIT+1], jdo[WDATA_LO-1:0]};

    // Strobe priority and overrun detection
    always_comb begin
        sel_b      = take_action_ocimem_b;
        sel_a      = take_action_ocimem_a & ~take_action_ocimem_b;
        sel_n      = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
        any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        blocked    = pending | busy;
        want_rd    = (sel_a & jdo[RD_BIT]) | sel_n;
        queue_cmd  = (want_rd | sel_b) & ~blocked;
        overrun    = any_strobe & blocked;
        // A plain address load is honoured even while blocked; a load that
        // also asks for a read is dropped as a whole.
        load_addr  = sel_a & (~blocked | ~jdo[RD_BIT]);
    end

    // Pending slot, address pointer and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending       <= 1'b0;
            pend_wr       <= 1'b0;
            pend_data     <= '0;
            jaddr         <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            // An explicit address load overrides the post-access increment
            if (load_addr) begin
                jaddr <= jdo[ADDR_LSB +: ADDR_W];
            end else if (done) begin
                jaddr <= jaddr + ADDR_W'(1);
            end

            if (queue_cmd) begin
                pending <= 1'b1;
                pend_wr <= sel_b;
                if (sel_b) begin
                    pend_data <= jdo[WDATA_HI:WDATA_LO];
                end
            end else if (done) begin
                pending <= 1'b0;
            end

            if (queue_cmd) begin
                monitor_ready <= 1'b0;
            end else if (done) begin
                monitor_ready <= 1'b1;
            end

            if (overrun) begin
                monitor_error <= 1'b1;
            end else if (sel_a & jdo[CLRERR_BIT]) begin
                monitor_error <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_0_ocimem_arbiter.sv
// OCI debug RAM arbiter.
// Shares one single-port synchronous RAM between JTAG debug commands and the
// CPU slave port. JTAG wins while the CPU is halted, idle, or after the
// pending JTAG request has lost STARVE_MAX arbitration rounds.
// Ports:
//   clk, reset                 clock, async active-high reset
//   jdo, take_*                JTAG command interface
//   debugack                   CPU halted in debug mode
//   cpu_req/wr/addr/wdata      CPU slave request
//   cpu_rdata, cpu_waitrequest CPU slave response
//   ram_addr/wdata/wr/rd       RAM command (combinational)
//   ram_rdata                  RAM read data, one cycle after ram_rd
//   MonDReg                    last JTAG read data
//   monitor_ready              JTAG command complete
//   monitor_error              sticky overrun flag
module cpu_0_ocimem_arbiter
    import cpu_0_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [DATA_W-1:0]     cpu_rdata_q;
    logic                  pending;
    logic                  pend_wr;
    logic [DATA_W-1:0]     pend_data;
    logic [ADDR_W-1:0]     jaddr;
    logic                  busy;
    logic                  jtag_done;
    logic                  jtag_grant;
    logic                  cpu_grant;

    assign busy = (state_q != IDLE);

    cpu_0_ocimem_cmd_decode #(
        .ADDR_W (ADDR_W)
    ) u_cmd_decode (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .busy                    (busy),
        .done                    (jtag_done),
        .pending                 (pending),
        .pend_wr                 (pend_wr),
        .pend_data               (pend_data),
        .jaddr                   (jaddr),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, next state and RAM/CPU handshake
    always_comb begin
        state_d         = state_q;
        ram_addr        = jaddr;
        ram_wdata       = pend_data;
        ram_wr          = 1'b0;
        ram_rd          = 1'b0;
        cpu_waitrequest = 1'b1;
        jtag_grant      = 1'b0;
        cpu_grant       = 1'b0;
        jtag_done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending && (debugack || !cpu_req || starve_cnt == STARVE_LIM)) begin
                    jtag_grant = 1'b1;
                    if (pend_wr) begin
                        ram_wr    = 1'b1;
                        jtag_done = 1'b1;
                    end else begin
                        ram_rd  = 1'b1;
                        state_d = J_RD;
                    end
                end else if (cpu_req) begin
                    cpu_grant = 1'b1;
                    ram_addr  = cpu_addr;
                    if (cpu_wr) begin
                        ram_wr          = 1'b1;
                        ram_wdata       = cpu_wdata;
                        cpu_waitrequest = 1'b0;
                    end else begin
                        ram_rd  = 1'b1;
                        state_d = C_RD;
                    end
                end
            end
            J_RD: begin
                jtag_done = 1'b1;
                state_d   = IDLE;
            end
            C_RD: begin
                cpu_waitrequest = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter and read-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt  <= '0;
            MonDReg     <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (jtag_grant) begin
                starve_cnt <= '0;
            end else if (pending && cpu_grant && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end

            if (state_q == J_RD) begin
                MonDReg <= ram_rdata;
            end

            if (state_q == C_RD) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

    // The CPU samples read data in the cycle waitrequest drops, which is the
    // cycle the RAM returns it; outside that cycle the last read is held.
    assign cpu_rdata = (state_q == C_RD) ? ram_rdata : cpu_rdata_q;

endmodule
